// File: rtl/dm_sba_target.sv
// rtl/dm_sba_target.sv - system-bus target RAM with grant wait states and fixed response latency
//
// Purpose: responder for the debug-module req/gnt/r_valid system bus. It is a
// byte-addressed, word-organised RAM. Each request is granted after GntDelay
// wait states. Each granted access returns exactly one response RespLatency
// cycles later. Responses come back in order. Accesses outside the RAM window
// get an error response.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   slave_req_i      request, held by the master until granted
//   slave_add_i      byte address
//   slave_we_i       1 = write, 0 = read
//   slave_wdata_i    write data
//   slave_be_i       byte enables
//   slave_gnt_o      request accepted this cycle (combinational)
//   slave_r_valid_o  response valid
//   slave_r_rdata_o  read data, 0 for writes, errors and idle cycles
//   slave_r_err_o    response is an error, qualified by slave_r_valid_o
//   busy_o           a granted response is still in flight
//
// Optional feature macro: DM_SBA_TARGET_READ_BE_EN
//   When defined, read response byte lanes whose byte enable is 0 are forced to 0.
//   When undefined, byte enables are ignored on reads.

module dm_sba_target #(
  parameter int unsigned BusWidth    = 32,
  parameter int unsigned NumWords    = 256,
  parameter logic [63:0] BaseAddr    = 64'h0,
  parameter int unsigned GntDelay    = 0,
  parameter int unsigned RespLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slave_req_i,
  input  logic [BusWidth-1:0]   slave_add_i,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  output logic                  slave_gnt_o,
  output logic                  slave_r_valid_o,
  output logic [BusWidth-1:0]   slave_r_rdata_o,
  output logic                  slave_r_err_o,
  output logic                  busy_o
);

  localparam int unsigned BeWidth   = BusWidth / 8;
  localparam int unsigned AddrShift = $clog2(BeWidth);
  localparam int unsigned IdxWidth  = $clog2(NumWords);
  localparam int unsigned WordAddrW = BusWidth - AddrShift;

  localparam logic [BusWidth-1:0]  BaseFull    = BaseAddr[BusWidth-1:0];
  localparam logic [WordAddrW-1:0] BaseWord    = BaseFull[BusWidth-1:AddrShift];
  localparam logic [WordAddrW-1:0] DepthWords  = WordAddrW'(NumWords);
  localparam logic [3:0]           GntDelayCnt = 4'(GntDelay);

  // Address decode. The base is aligned to the RAM size, so subtracting at
  // word granularity gives the same result as (add - base) >> shift. The
  // >= compare is what rejects addresses below the base after wrap-around.
  logic [WordAddrW-1:0] word_off;
  logic [IdxWidth-1:0]  idx;
  logic                 in_range;

  assign word_off = slave_add_i[BusWidth-1:AddrShift] - BaseWord;
  assign in_range = (slave_add_i >= BaseFull) && (word_off < DepthWords);
  assign idx      = word_off[IdxWidth-1:0];

  // Wait-state counter. The grant is gated by reset so that no write can
  // commit while the block is held in reset.
  logic [3:0] wcnt;

  assign slave_gnt_o = slave_req_i && !rst_i && (wcnt == GntDelayCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt <= 4'd0;
    end else if (slave_req_i && !slave_gnt_o) begin
      wcnt <= wcnt + 4'd1;
    end else begin
      wcnt <= 4'd0;
    end
  end

  // RAM storage. The RAM is not reset, so committed writes survive a reset.
  logic [BusWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i) begin
    if (slave_gnt_o && slave_we_i && in_range) begin
      for (int k = 0; k < BeWidth; k++) begin
        if (slave_be_i[k]) begin
          mem_q[idx][8*k +: 8] <= slave_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response payload, captured in the grant cycle. The read sees the RAM
  // contents before this cycle's write edge.
  logic [BusWidth-1:0] rd_word;
  logic [BusWidth-1:0] rd_mask;
  logic [BusWidth-1:0] resp_data;
  logic                resp_err;

  always_comb begin
    rd_mask = '1;
`ifdef DM_SBA_TARGET_READ_BE_EN
    for (int k = 0; k < BeWidth; k++) begin
      rd_mask[8*k +: 8] = {8{slave_be_i[k]}};
    end
`endif
    rd_word  = mem_q[idx];
    resp_err = !in_range;
    if (slave_we_i || !in_range) begin
      resp_data = '0;
    end else begin
      resp_data = rd_word & rd_mask;
    end
  end

  // Fixed-latency response pipeline. Data and err are loaded as 0 in
  // non-grant cycles, so the outputs are 0 whenever valid is low.
  logic [RespLatency-1:0] pipe_valid;
  logic [RespLatency-1:0] pipe_err;
  logic [BusWidth-1:0]    pipe_data [RespLatency];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RespLatency; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= slave_gnt_o;
      pipe_err[0]   <= slave_gnt_o && resp_err;
      pipe_data[0]  <= slave_gnt_o ? resp_data : '0;
      for (int i = 1; i < RespLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign slave_r_valid_o = pipe_valid[RespLatency-1];
  assign slave_r_err_o   = pipe_err[RespLatency-1];
  assign slave_r_rdata_o = pipe_data[RespLatency-1];
  assign busy_o          = |pipe_valid;

endmodule

// File: tb/tb_dm_sba_target.sv
// tb/tb_dm_sba_target.sv - directed self-checking bench for dm_sba_target

module tb_dm_sba_target;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef DM_SBA_TARGET_READ_BE_EN
  localparam logic [31:0] BeRdExp = 32'h0000BE00;
`else
  localparam logic [31:0] BeRdExp = 32'hDEADBEAA;
`endif

  logic a_req, a_we, a_gnt, a_rv, a_err, a_busy;
  logic [31:0] a_add, a_wdata, a_rd;
  logic [3:0]  a_be;
  logic b_req, b_we, b_gnt, b_rv, b_err, b_busy;
  logic [31:0] b_add, b_wdata, b_rd;
  logic [3:0]  b_be;
  logic c_req, c_we, c_gnt, c_rv, c_err, c_busy;
  logic [31:0] c_add, c_wdata, c_rd;
  logic [3:0]  c_be;

  dm_sba_target #(.BusWidth(32), .NumWords(256), .BaseAddr(64'h0), .GntDelay(0), .RespLatency(1)) u_a (
    .clk_i(clk), .rst_i(rst), .slave_req_i(a_req), .slave_add_i(a_add), .slave_we_i(a_we),
    .slave_wdata_i(a_wdata), .slave_be_i(a_be), .slave_gnt_o(a_gnt), .slave_r_valid_o(a_rv),
    .slave_r_rdata_o(a_rd), .slave_r_err_o(a_err), .busy_o(a_busy));

  dm_sba_target #(.BusWidth(32), .NumWords(256), .BaseAddr(64'h0), .GntDelay(3), .RespLatency(3)) u_b (
    .clk_i(clk), .rst_i(rst), .slave_req_i(b_req), .slave_add_i(b_add), .slave_we_i(b_we),
    .slave_wdata_i(b_wdata), .slave_be_i(b_be), .slave_gnt_o(b_gnt), .slave_r_valid_o(b_rv),
    .slave_r_rdata_o(b_rd), .slave_r_err_o(b_err), .busy_o(b_busy));

  dm_sba_target #(.BusWidth(32), .NumWords(256), .BaseAddr(64'h0), .GntDelay(0), .RespLatency(4)) u_c (
    .clk_i(clk), .rst_i(rst), .slave_req_i(c_req), .slave_add_i(c_add), .slave_we_i(c_we),
    .slave_wdata_i(c_wdata), .slave_be_i(c_be), .slave_gnt_o(c_gnt), .slave_r_valid_o(c_rv),
    .slave_r_rdata_o(c_rd), .slave_r_err_o(c_err), .busy_o(c_busy));

  task automatic drv_a(input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    a_req = r; a_we = w; a_add = ad; a_wdata = wd; a_be = be;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    b_req = r; b_we = w; b_add = ad; b_wdata = wd; b_be = be;
  endtask

  task automatic drv_c(input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    c_req = r; c_we = w; c_add = ad; c_wdata = wd; c_be = be;
  endtask

  initial begin
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    drv_c(0, 0, 0, 0, 0);
    rst = 1'b1;

    @(negedge clk); drv_a(1, 1, 32'h10, 32'h0, 4'hF); #1;
    chk("rst_gnt", a_gnt, 1'b0);
    chk("rst_rv", a_rv, 1'b0);
    chk("rst_rd", a_rd, 32'h0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_busy", a_busy, 1'b0);

    @(negedge clk); rst = 1'b0; drv_a(1, 1, 32'h10, 32'hDEADBEEF, 4'hF); #1;
    chk("a_wr_gnt", a_gnt, 1'b1);
    @(negedge clk); drv_a(1, 0, 32'h10, 32'h0, 4'hF); #1;
    chk("a_wr_rv", a_rv, 1'b1);
    chk("a_wr_err", a_err, 1'b0);
    chk("a_wr_rd", a_rd, 32'h0);
    chk("a_wr_busy", a_busy, 1'b1);
    chk("a_rd_gnt", a_gnt, 1'b1);
    @(negedge clk); drv_a(1, 1, 32'h10, 32'h000000AA, 4'h1); #1;
    chk("a_rd_rv", a_rv, 1'b1);
    chk("a_rd_data", a_rd, 32'hDEADBEEF);
    chk("a_rd_err", a_err, 1'b0);
    @(negedge clk); drv_a(1, 0, 32'h10, 32'h0, 4'h2); #1;
    chk("a_be_wr_rv", a_rv, 1'b1);
    @(negedge clk); drv_a(0, 0, 32'h0, 32'h0, 4'h0); #1;
    chk("a_be_rd_rv", a_rv, 1'b1);
    chk("a_be_rd_data", a_rd, BeRdExp);
    @(negedge clk); #1;
    chk("a_idle_rv", a_rv, 1'b0);
    chk("a_idle_rd", a_rd, 32'h0);
    chk("a_idle_busy", a_busy, 1'b0);
    chk("a_idle_gnt", a_gnt, 1'b0);

    @(negedge clk); drv_a(1, 1, 32'h0, 32'h11111111, 4'hF);
    @(negedge clk); drv_a(1, 1, 32'h400, 32'h12345678, 4'hF); #1;
    chk("a_w0_err", a_err, 1'b0);
    @(negedge clk); drv_a(1, 0, 32'h400, 32'h0, 4'hF); #1;
    chk("a_oor_wr_rv", a_rv, 1'b1);
    chk("a_oor_wr_err", a_err, 1'b1);
    chk("a_oor_wr_rd", a_rd, 32'h0);
    @(negedge clk); drv_a(1, 0, 32'h0, 32'h0, 4'hF); #1;
    chk("a_oor_rd_rv", a_rv, 1'b1);
    chk("a_oor_rd_err", a_err, 1'b1);
    chk("a_oor_rd_rd", a_rd, 32'h0);
    @(negedge clk); drv_a(1, 1, 32'h3FC, 32'hCAFEF00D, 4'hF); #1;
    chk("a_w0_unchanged", a_rd, 32'h11111111);
    chk("a_w0_rd_err", a_err, 1'b0);
    @(negedge clk); drv_a(1, 0, 32'h3FC, 32'h0, 4'hF); #1;
    chk("a_last_wr_err", a_err, 1'b0);
    @(negedge clk); drv_a(0, 0, 32'h0, 32'h0, 4'h0); #1;
    chk("a_last_rd", a_rd, 32'hCAFEF00D);
    chk("a_last_rd_err", a_err, 1'b0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 4) begin
        drv_c(1, 1, 32'(i * 4), 32'(i + 1), 4'hF);
      end else if (i < 8) begin
        drv_c(1, 0, 32'((i - 4) * 4), 32'h0, 4'hF);
      end else begin
        drv_c(0, 0, 32'h0, 32'h0, 4'h0);
      end
      #1;
      chk("c_gnt", c_gnt, 32'(i < 8));
      chk("c_rv", c_rv, 32'(i >= 4));
      chk("c_busy", c_busy, 32'(i >= 1));
      if (i >= 8) begin
        chk("c_rd_data", c_rd, 32'(i - 7));
      end else begin
        chk("c_rd_zero", c_rd, 32'h0);
      end
    end
    @(negedge clk); #1;
    chk("c_end_rv", c_rv, 1'b0);
    chk("c_end_busy", c_busy, 1'b0);

    @(negedge clk); drv_b(1, 1, 32'h10, 32'h5A5A5A5A, 4'hF); #1;
    chk("b_wait0", b_gnt, 1'b0);
    @(negedge clk); #1;
    chk("b_wait1", b_gnt, 1'b0);
    @(negedge clk); #1;
    chk("b_wait2", b_gnt, 1'b0);
    @(negedge clk); #1;
    chk("b_wr_gnt", b_gnt, 1'b1);
    @(negedge clk); drv_b(1, 0, 32'h10, 32'h0, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk("b_rd_wait", b_gnt, 1'b0);
      chk("b_wr_rv", b_rv, 32'(k == 3));
      chk("b_busy", b_busy, 1'b1);
    end
    chk("b_wr_err", b_err, 1'b0);
    @(negedge clk); #1;
    chk("b_rd_gnt", b_gnt, 1'b1);

    @(negedge clk); rst = 1'b1; drv_b(0, 0, 32'h0, 32'h0, 4'h0); #1;
    chk("b_pend_busy", b_busy, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk); rst = 1'b0; #1;
      chk("b_drop_rv", b_rv, 1'b0);
      chk("b_drop_busy", b_busy, 1'b0);
    end

    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j == 0) begin
        drv_b(1, 0, 32'h10, 32'h0, 4'hF);
        drv_a(1, 0, 32'h10, 32'h0, 4'hF);
      end
      if (j == 1) drv_a(0, 0, 32'h0, 32'h0, 4'h0);
      if (j == 4) drv_b(0, 0, 32'h0, 32'h0, 4'h0);
      #1;
      if (j == 1) begin
        chk("a_persist", a_rd, 32'hDEADBEAA);
      end
      if (j <= 3) begin
        chk("b_persist_gnt", b_gnt, 32'(j == 3));
      end
      if (j == 6) begin
        chk("b_persist_rv", b_rv, 1'b1);
        chk("b_persist_rd", b_rd, 32'h5A5A5A5A);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
